// File: rtl/gpio_comm_pkg.sv
// Shared turn codes, gpio bit positions and FSM state types for the
// PULPino side of the GPIO byte-exchange link.
package gpio_comm_pkg;

  localparam logic [1:0] TURN_IDLE    = 2'b00;
  localparam logic [1:0] TURN_BYTE    = 2'b01;
  localparam logic [1:0] TURN_LAST    = 2'b10;
  localparam logic [1:0] TURN_ILLEGAL = 2'b11;

  localparam int DATA_LSB          = 0;
  localparam int OUT_IO_TURN       = 8;
  localparam int IN_IO_TURN_LSB    = 9;
  localparam int IN_PULP_TURN_LSB  = 8;
  localparam int OUT_PULP_TURN_LSB = 10;

  typedef enum logic {
    RX_IDLE,
    RX_ACK
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_WAIT_ACK,
    TX_WAIT_REL
  } tx_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } rx_entry_t;

  function automatic logic is_data_turn(input logic [1:0] t);
    return (t == TURN_BYTE) || (t == TURN_LAST);
  endfunction

endpackage

// File: rtl/gpio_comm_rx_fifo.sv
// First-word fall-through buffer between the RX handshake decoder and the
// byte consumer. Flags come straight off the registered occupancy count.
module gpio_comm_rx_fifo
  import gpio_comm_pkg::*;
#(
  parameter int pDEPTH = 4
) (
  input  logic      clk,
  input  logic      reset_i,
  input  logic      push,
  input  rx_entry_t push_data,
  output logic      full,
  input  logic      pop,
  output rx_entry_t pop_data,
  output logic      empty
);

  localparam int AW = $clog2(pDEPTH);

  rx_entry_t       mem [pDEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(pDEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Head is forced to zero when empty so stale entries never show.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/gpio_pulpino_endpoint.sv
// PULPino end of the GPIO byte link: decodes the inbound turn handshake into
// a buffered byte stream and drives outbound bytes with the return handshake.
module gpio_pulpino_endpoint
  import gpio_comm_pkg::*;
#(
  parameter int pRX_DEPTH    = 4,
  parameter int pSYNC_STAGES = 0
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  output logic [7:0]  rx_data,
  output logic        rx_last,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [7:0]  tx_data,
  input  logic        tx_last,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        proto_err
);

  logic [2:0] io_turn_s;
  logic       unused_gpio;

  assign unused_gpio = ^gpio_in[31:11];

  if (pSYNC_STAGES == 0) begin : g_direct
    assign io_turn_s = gpio_in[10:8];
  end else begin : g_sync
    logic [2:0] sync_q [pSYNC_STAGES];
    always_ff @(posedge clk) begin
      if (reset_i) begin
        for (int i = 0; i < pSYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
        sync_q[0] <= gpio_in[10:8];
        for (int i = 1; i < pSYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
    end
    assign io_turn_s = sync_q[pSYNC_STAGES-1];
  end

  logic       out_io_ack;
  logic [1:0] in_io_turn;

  assign out_io_ack = io_turn_s[OUT_IO_TURN - OUT_IO_TURN];
  assign in_io_turn = io_turn_s[IN_IO_TURN_LSB - OUT_IO_TURN +: 2];

  // RX buffer
  rx_entry_t fifo_din;
  rx_entry_t fifo_dout;
  logic      fifo_full;
  logic      fifo_empty;
  logic      rx_push;

  assign fifo_din.data = gpio_in[DATA_LSB +: 8];
  assign fifo_din.last = (in_io_turn == TURN_LAST);

  gpio_comm_rx_fifo #(.pDEPTH(pRX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset_i   (reset_i),
    .push      (rx_push),
    .push_data (fifo_din),
    .full      (fifo_full),
    .pop       (rx_ready),
    .pop_data  (fifo_dout),
    .empty     (fifo_empty)
  );

  assign rx_data  = fifo_dout.data;
  assign rx_last  = fifo_dout.last;
  assign rx_valid = ~fifo_empty;

  // RX FSM
  rx_state_e  rx_state_q, rx_state_d;
  logic [1:0] rx_turn_q, rx_turn_d;
  logic       err_set;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      rx_state_q <= RX_IDLE;
      rx_turn_q  <= TURN_IDLE;
      proto_err  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_turn_q  <= rx_turn_d;
      if (err_set) proto_err <= 1'b1;
    end
  end

  // Withholding the ack while full is what stalls the IO side losslessly.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_turn_d  = rx_turn_q;
    rx_push    = 1'b0;
    err_set    = 1'b0;
    if (in_io_turn == TURN_ILLEGAL) begin
      err_set = 1'b1;
    end else begin
      case (rx_state_q)
        RX_IDLE: begin
          if (is_data_turn(in_io_turn) && !fifo_full) begin
            rx_push    = 1'b1;
            rx_turn_d  = in_io_turn;
            rx_state_d = RX_ACK;
          end
        end
        RX_ACK: begin
          if (in_io_turn == TURN_IDLE) begin
            rx_turn_d  = TURN_IDLE;
            rx_state_d = RX_IDLE;
          end else if (in_io_turn != rx_turn_q) begin
            err_set = 1'b1;
          end
        end
        default: begin
          rx_state_d = RX_IDLE;
          rx_turn_d  = TURN_IDLE;
        end
      endcase
    end
  end

  // TX FSM
  tx_state_e  tx_state_q, tx_state_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic [1:0] tx_turn_q, tx_turn_d;

  assign tx_ready = (tx_state_q == TX_IDLE) & ~reset_i;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      tx_state_q <= TX_IDLE;
      tx_byte_q  <= '0;
      tx_turn_q  <= TURN_IDLE;
    end else begin
      tx_state_q <= tx_state_d;
      tx_byte_q  <= tx_byte_d;
      tx_turn_q  <= tx_turn_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_byte_d  = tx_byte_q;
    tx_turn_d  = tx_turn_q;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_valid) begin
          tx_byte_d  = tx_data;
          tx_turn_d  = tx_last ? TURN_LAST : TURN_BYTE;
          tx_state_d = TX_WAIT_ACK;
        end
      end
      TX_WAIT_ACK: begin
        if (out_io_ack) begin
          tx_turn_d  = TURN_IDLE;
          tx_state_d = TX_WAIT_REL;
        end
      end
      TX_WAIT_REL: begin
        if (!out_io_ack) tx_state_d = TX_IDLE;
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_turn_d  = TURN_IDLE;
      end
    endcase
  end

  always_comb begin
    gpio_out = '0;
    gpio_out[DATA_LSB +: 8]          = tx_byte_q;
    gpio_out[IN_PULP_TURN_LSB +: 2]  = rx_turn_q;
    gpio_out[OUT_PULP_TURN_LSB +: 2] = tx_turn_q;
  end

endmodule

// File: tb/tb_gpio_pulpino_endpoint.sv
// Directed bench for gpio_pulpino_endpoint: a vector table for the basic
// handshakes plus sequences for full-buffer stall, violations, reset, concurrency.
module tb_gpio_pulpino_endpoint;
  import gpio_comm_pkg::*;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic [7:0]  rx_data;
  logic        rx_last, rx_valid;
  logic        rx_ready = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_last = 1'b0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic        proto_err;

  logic [7:0]  io_byte = 8'h00;
  logic        io_ack = 1'b0;
  logic [1:0]  io_turn = 2'b00;

  assign gpio_in = {21'h0, io_turn, io_ack, io_byte};

  always #5 clk = ~clk;

  gpio_pulpino_endpoint #(.pRX_DEPTH(4), .pSYNC_STAGES(0)) dut (
    .clk       (clk),
    .reset_i   (reset_i),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .rx_data   (rx_data),
    .rx_last   (rx_last),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_last   (tx_last),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .proto_err (proto_err)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    io_turn = TURN_IDLE; io_ack = 1'b0; rx_ready = 1'b0; tx_valid = 1'b0;
    reset_i = 1'b1;
    step(); step();
    chk("rst_gpio_out", gpio_out, 32'h0);
    chk("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
    chk("rst_tx_ready", {31'h0, tx_ready}, 32'h0);
    reset_i = 1'b0;
    step();
    chk("post_rst_tx_ready", {31'h0, tx_ready}, 32'h1);
    chk("post_rst_err", {31'h0, proto_err}, 32'h0);
  endtask

  // IO side of one inbound transfer: offer, wait for ack, release, wait for release.
  task automatic send_rx(input logic [7:0] b, input logic [1:0] t);
    int n;
    io_byte = b; io_turn = t; n = 0;
    do begin step(); n++; end while (gpio_out[9:8] !== t && n < 100);
    chk("rx_ack", {30'h0, gpio_out[9:8]}, {30'h0, t});
    io_turn = TURN_IDLE; n = 0;
    do begin step(); n++; end while (gpio_out[9:8] !== TURN_IDLE && n < 100);
    chk("rx_rel", {30'h0, gpio_out[9:8]}, 32'h0);
  endtask

  typedef struct {
    logic [7:0]  byt;
    logic        ack;
    logic [1:0]  turn;
    logic        rdy;
    logic        tv;
    logic [7:0]  td;
    logic        tl;
    logic [11:0] e_out;
    logic        e_rxv;
    logic [7:0]  e_rxd;
    logic        e_rxl;
    logic        e_txr;
    logic        e_err;
  } vec_t;

  vec_t vt [13];
  logic [8:0] rxq [$];
  logic [8:0] txq [$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{8'hA5, 1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0, 12'h100, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
    vt[1]  = '{8'hA5, 1'b0, 2'b01, 1'b0, 1'b0, 8'h00, 1'b0, 12'h100, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{8'hA5, 1'b0, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 12'h000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vt[3]  = '{8'h00, 1'b0, 2'b00, 1'b0, 1'b1, 8'h3C, 1'b1, 12'h83C, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 12'h83C, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 12'h03C, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{8'h00, 1'b1, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 12'h03C, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 12'h03C, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vt[8]  = '{8'h77, 1'b0, 2'b10, 1'b0, 1'b1, 8'h5A, 1'b0, 12'h65A, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{8'h77, 1'b1, 2'b00, 1'b1, 1'b0, 8'h00, 1'b0, 12'h05A, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vt[10] = '{8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 12'h05A, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vt[11] = '{8'h00, 1'b0, 2'b11, 1'b0, 1'b0, 8'h00, 1'b0, 12'h05A, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    vt[12] = '{8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00, 1'b0, 12'h05A, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};

    do_reset();
    chk("rst_rx_data", {24'h0, rx_data}, 32'h0);
    chk("rst_rx_last", {31'h0, rx_last}, 32'h0);

    // Vector table: inputs held across one rising edge, outputs checked after it.
    for (int i = 0; i < 13; i++) begin
      io_byte = vt[i].byt; io_ack = vt[i].ack; io_turn = vt[i].turn;
      rx_ready = vt[i].rdy; tx_valid = vt[i].tv; tx_data = vt[i].td; tx_last = vt[i].tl;
      step();
      chk($sformatf("v%0d_gpio_out", i), gpio_out, {20'h0, vt[i].e_out});
      chk($sformatf("v%0d_rx_valid", i), {31'h0, rx_valid}, {31'h0, vt[i].e_rxv});
      chk($sformatf("v%0d_rx_data", i), {24'h0, rx_data}, {24'h0, vt[i].e_rxd});
      chk($sformatf("v%0d_rx_last", i), {31'h0, rx_last}, {31'h0, vt[i].e_rxl});
      chk($sformatf("v%0d_tx_ready", i), {31'h0, tx_ready}, {31'h0, vt[i].e_txr});
      chk($sformatf("v%0d_proto_err", i), {31'h0, proto_err}, {31'h0, vt[i].e_err});
    end
    io_turn = TURN_IDLE; io_ack = 1'b0; rx_ready = 1'b0; tx_valid = 1'b0;

    // Code change while acknowledging: error flagged, ack turn held, single push.
    do_reset();
    io_byte = 8'h11; io_turn = TURN_BYTE;
    step();
    chk("viol_ack", {30'h0, gpio_out[9:8]}, 32'h1);
    io_turn = TURN_LAST;
    step();
    chk("viol_err", {31'h0, proto_err}, 32'h1);
    chk("viol_hold", {30'h0, gpio_out[9:8]}, 32'h1);
    io_turn = TURN_IDLE;
    step();
    chk("viol_rel", {30'h0, gpio_out[9:8]}, 32'h0);
    chk("viol_head", {23'h0, rx_last, rx_data}, {23'h0, 1'b0, 8'h11});
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    chk("viol_one_push", {31'h0, rx_valid}, 32'h0);

    // Full buffer: fifth byte stalls until a pop, then is acked two cycles later.
    do_reset();
    for (int i = 0; i < 4; i++) send_rx(8'h10 + 8'(i), TURN_BYTE);
    io_byte = 8'h14; io_turn = TURN_BYTE;
    repeat (5) step();
    chk("full_stall", {30'h0, gpio_out[9:8]}, 32'h0);
    chk("full_head", {24'h0, rx_data}, 32'h10);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    chk("full_pop_plus1", {30'h0, gpio_out[9:8]}, 32'h0);
    step();
    chk("full_pop_plus2", {30'h0, gpio_out[9:8]}, 32'h1);
    io_turn = TURN_IDLE;
    step();
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("full_order%0d", i), {23'h0, rx_valid, rx_data}, {23'h0, 1'b1, 8'h10 + 8'(i)});
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
    end
    chk("full_drained", {31'h0, rx_valid}, 32'h0);

    // Reset while waiting for the TX ack, with RX data buffered.
    do_reset();
    send_rx(8'h42, TURN_BYTE);
    tx_valid = 1'b1; tx_data = 8'h99; tx_last = 1'b0;
    step();
    tx_valid = 1'b0;
    chk("rst_mid_tx_out", {20'h0, gpio_out[11:0]}, 32'h499);
    reset_i = 1'b1;
    step();
    chk("rst_mid_gpio", gpio_out, 32'h0);
    chk("rst_mid_rxv", {31'h0, rx_valid}, 32'h0);
    chk("rst_mid_txr", {31'h0, tx_ready}, 32'h0);
    reset_i = 1'b0;
    step();
    chk("rst_mid_txr_after", {31'h0, tx_ready}, 32'h1);
    chk("rst_mid_gpio_after", gpio_out, 32'h0);

    // Concurrent RX and TX streams with random handshake delays.
    do_reset();
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send_rx(8'(i + 1), (i == 7) ? TURN_LAST : TURN_BYTE);
          repeat ($urandom_range(0, 3)) step();
        end
      end
      begin
        int got = 0;
        for (int c = 0; c < 1500 && got < 8; c++) begin
          rx_ready = ($urandom_range(0, 1) == 1);
          if (rx_valid && rx_ready) begin
            rxq.push_back({rx_last, rx_data});
            got++;
          end
          step();
        end
        rx_ready = 1'b0;
      end
      begin
        for (int i = 0; i < 8; i++) begin
          int n = 0;
          tx_data = 8'h81 + 8'(i); tx_last = (i == 7); tx_valid = 1'b1;
          while (!tx_ready && n < 300) begin step(); n++; end
          step();
          tx_valid = 1'b0;
          repeat ($urandom_range(0, 2)) step();
        end
      end
      begin
        for (int i = 0; i < 8; i++) begin
          int n = 0;
          while (gpio_out[11:10] == TURN_IDLE && n < 300) begin step(); n++; end
          txq.push_back({gpio_out[11:10] == TURN_LAST, gpio_out[7:0]});
          repeat ($urandom_range(0, 3)) step();
          io_ack = 1'b1;
          n = 0;
          while (gpio_out[11:10] != TURN_IDLE && n < 50) begin step(); n++; end
          repeat ($urandom_range(0, 3)) step();
          io_ack = 1'b0;
        end
      end
    join

    chk("conc_rx_count", rxq.size(), 32'd8);
    chk("conc_tx_count", txq.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      logic [8:0] ra, ta;
      ra = (i < rxq.size()) ? rxq[i] : 9'h1FF;
      ta = (i < txq.size()) ? txq[i] : 9'h1FF;
      chk($sformatf("conc_rx%0d", i), {23'h0, ra}, {23'h0, (i == 7), 8'(i + 1)});
      chk($sformatf("conc_tx%0d", i), {23'h0, ta}, {23'h0, (i == 7), 8'h81 + 8'(i)});
    end
    chk("conc_err", {31'h0, proto_err}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gpio_pulpino_endpoint.md
# gpio_pulpino_endpoint

Hardware implementation of the PULPino end of the GPIO byte-exchange protocol served on the FPGA side by `gpio_pulpino_comm`. It decodes the inbound four-phase turn handshake into a buffered byte stream and encodes an outbound byte stream into the return handshake. Uses: a synthesizable stand-in for PULPino firmware during bring-up, and the link partner in loopback benches. It lives in the `pulpino_clk` domain and connects directly to the `gpio_in`/`gpio_out` vectors.

## Interface
Parameters:
- `pRX_DEPTH`, 4, RX buffer entries; power of two, at least 2.
- `pSYNC_STAGES`, 0, synchronizer flops on `gpio_in[10:8]`; 0 for same-clock use, 2 for an asynchronous partner.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  `pulpino_clk`; all logic on the rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `gpio_in`  in  32  from the IO side: [7:0] inbound byte, [8] `data_out_io_turn`, [10:9] `data_in_io_turn`; [31:11] ignored.
- `gpio_out`  out  32  to the IO side: [7:0] outbound byte, [9:8] `data_in_pulpino_turn`, [11:10] `data_out_pulpino_turn`; [31:12] constant 0.
- `rx_data`  out  8  head byte of the RX buffer.
- `rx_last`  out  1  head byte was sent with the LAST code.
- `rx_valid`  out  1  RX buffer not empty.
- `rx_ready`  in  1  consumer pops the head when `rx_valid & rx_ready`.
- `tx_data`  in  8  byte to send.
- `tx_last`  in  1  mark the byte as last.
- `tx_valid`  in  1  byte offered.
- `tx_ready`  out  1  byte accepted when `tx_valid & tx_ready`.
- `proto_err`  out  1  sticky protocol-violation flag; cleared only by reset.

## Operation
- Turn codes: IDLE=00, BYTE=01, LAST=10, and 11 is illegal.
- RX FSM, with states RX_IDLE and RX_ACK:
  - RX_IDLE: when `data_in_io_turn` is BYTE or LAST and the buffer is not full, push {`gpio_in[7:0]`, code==LAST}, set `data_in_pulpino_turn` to the same code, and go to RX_ACK.
  - RX_ACK: when `data_in_io_turn` returns to IDLE, set `data_in_pulpino_turn` to IDLE and go to RX_IDLE.
  - In RX_ACK, a different nonzero code sets `proto_err`; the FSM holds state.
  - Code 11 in any state sets `proto_err` and is otherwise ignored.
- Buffer full: no acknowledge is given, so the IO side stalls with no data loss.
- TX FSM, with states TX_IDLE, TX_WAIT_ACK and TX_WAIT_REL:
  - `tx_ready` = (state == TX_IDLE).
  - TX_IDLE, on accept: register `tx_data` onto `gpio_out[7:0]`, drive `data_out_pulpino_turn` = `tx_last` ? LAST : BYTE, and go to TX_WAIT_ACK.
  - TX_WAIT_ACK: when `data_out_io_turn` is 1, drive IDLE and go to TX_WAIT_REL.
  - TX_WAIT_REL: when `data_out_io_turn` is 0, go to TX_IDLE.
- `gpio_out[7:0]` holds the last sent byte until the next accept.
- RX and TX are fully independent and may run concurrently.

## Timing
- All outputs are registered, except `tx_ready` (state decode) and `rx_*` (buffer head).
- Reset values: `gpio_out`=0, `rx_valid`=0, `rx_data`=0, `rx_last`=0, `tx_ready`=1 in the cycle after reset deasserts (0 while `reset_i` is high), `proto_err`=0, buffer empty, both FSMs idle.
- Latency with `pSYNC_STAGES`=0: an IO code seen in cycle n produces the ack turn and `rx_valid` in cycle n+1. Each synchronizer stage adds one cycle.
- TX: accept in cycle n puts the byte and turn on `gpio_out` in n+1. An ack seen in cycle m clears the turn in m+1.
- Full and pop in the same cycle: the push decision uses the registered full flag, so no push occurs that cycle; the push happens the next cycle.
- Pointers wrap modulo `pRX_DEPTH`; the count is `clog2(pRX_DEPTH)+1` bits wide.
- Reset mid-handshake abandons the transfer. Turns drop to IDLE and buffer contents are discarded.

## Structure
- `gpio_comm_pkg` holds:
  - turn-code localparams TURN_IDLE, TURN_BYTE, TURN_LAST;
  - bit positions DATA_LSB=0, OUT_IO_TURN=8, IN_IO_TURN_LSB=9, IN_PULP_TURN_LSB=8, OUT_PULP_TURN_LSB=10;
  - the RX and TX state enums.
- One sub-module, `gpio_comm_rx_fifo`: a synchronous FIFO of 9-bit entries, depth `pRX_DEPTH`, with full/empty flags and first-word fall-through.
- The synchronizer is a generate loop inside the top; the two FSMs live in the top.

## Test plan
- Single RX byte: IO drives 0xA5 with code 01 → `data_in_pulpino_turn`=01 next cycle, `rx_data`=0xA5, `rx_last`=0; IO drops to 00 → turn 00 next cycle.
- Buffer full: `rx_ready`=0 while IO sends 5 bytes 0x10..0x14 with depth 4 → four bytes are acked and the fifth stalls. One pop → the fifth is acked two cycles later, and the pop order is 0x10..0x14.
- TX last byte: `tx_valid` with 0x3C and `tx_last`=1 → `gpio_out[7:0]`=0x3C and `[11:10]`=10. IO ack 1 → turn 00; `tx_ready` stays low until the ack drops to 0.
- Concurrent: an RX stream of 0x01..0x08 and a TX stream of 0x81..0x88 interleaved with random ack delays → both streams arrive intact and in order, with `proto_err`=0.
- Violations: code 11 in RX_IDLE → `proto_err`=1 and no push. A code change 01→10 in RX_ACK → `proto_err`=1 and state held.
- Reset during TX_WAIT_ACK → `gpio_out`=0 the next cycle, buffer empty, and `tx_ready` returns to 1 in the cycle after reset deasserts.
